// File: rtl/result_fmt_pkg.sv
// Shared types and defaults for the result formatter stages.
// Build option: LEADING_ZERO_SUPPRESS_EN (see result_bcd_serializer).
package result_fmt_pkg;

    localparam int IN_W_DEF   = 11;
    localparam int DIGITS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        EMIT = 2'd2
    } state_t;

    typedef logic [3:0] bcd_nibble_t;

endpackage

// File: rtl/dabble_add3.sv
// Double-dabble nibble correction: values of 5 or more get +3 before the shift.
module dabble_add3
    import result_fmt_pkg::*;
(
    input  bcd_nibble_t x,
    output bcd_nibble_t y
);

    assign y = (x >= 4'd5) ? x + 4'd3 : x;

endmodule

// File: rtl/result_bcd_serializer.sv
// Captures a binary result, converts it to BCD one double-dabble step per cycle and streams digits MSD-first.
// Build option: LEADING_ZERO_SUPPRESS_EN skips leading zero digits (value 0 still emits one '0').
//
// Stream handshake: dig/dig_last are held stable while dig_valid=1 and dig_ready=0; a digit is
// consumed on every rising edge where dig_valid and dig_ready are both high.
module result_bcd_serializer
    import result_fmt_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] res,
    input  logic            res_valid,
    output logic [3:0]      dig,
    output logic            dig_valid,
    input  logic            dig_ready,
    output logic            dig_last,
    output logic            busy,
    output logic            drop_err,
    output state_t          state_dbg
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int ITER_W = $clog2(IN_W + 1);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state;
    logic [IN_W-1:0]    bin;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_next;
    logic [IN_W-1:0]    bin_next;
    logic [ITER_W-1:0]  iter;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_dec;
    logic [IDX_W-1:0]   start_idx;
    logic [BCD_W+IN_W-1:0] shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        dabble_add3 u_add3 (
            .x (bcd[4*g +: 4]),
            .y (bcd_adj[4*g +: 4])
        );
    end

    // Correct-then-shift of the combined {bcd,bin} register; the carry out of the top nibble is always 0.
    assign shifted  = {bcd_adj, bin} << 1;
    assign bcd_next = shifted[BCD_W+IN_W-1 -: BCD_W];
    assign bin_next = shifted[IN_W-1:0];
    assign idx_dec  = idx - 1'b1;

    // First digit to emit, decided from the final BCD value on the CONV->EMIT step.
    always_comb begin
        start_idx = IDX_W'(DIGITS - 1);
`ifdef LEADING_ZERO_SUPPRESS_EN
        start_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_next[4*i +: 4] != 4'd0) start_idx = IDX_W'(i);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bin       <= '0;
            bcd       <= '0;
            iter      <= '0;
            idx       <= '0;
            dig       <= '0;
            dig_valid <= 1'b0;
            dig_last  <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            if (res_valid && state != IDLE) drop_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (res_valid) begin
                        bin   <= res;
                        bcd   <= '0;
                        iter  <= ITER_W'(IN_W);
                        state <= CONV;
                    end
                end
                CONV: begin
                    bcd  <= bcd_next;
                    bin  <= bin_next;
                    iter <= iter - 1'b1;
                    if (iter == ITER_W'(1)) begin
                        state     <= EMIT;
                        idx       <= start_idx;
                        dig       <= bcd_next[{start_idx, 2'b00} +: 4];
                        dig_valid <= 1'b1;
                        dig_last  <= (start_idx == '0);
                    end
                end
                EMIT: begin
                    if (dig_ready) begin
                        if (idx == '0) begin
                            state     <= IDLE;
                            dig       <= '0;
                            dig_valid <= 1'b0;
                            dig_last  <= 1'b0;
                        end else begin
                            idx      <= idx_dec;
                            dig      <= bcd[{idx_dec, 2'b00} +: 4];
                            dig_last <= (idx == IDX_W'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_result_bcd_serializer.sv
// Bench for result_bcd_serializer: decimal reference model with an expected digit queue.
// Honours LEADING_ZERO_SUPPRESS_EN the same way the design build does.
module tb_result_bcd_serializer;
    import result_fmt_pkg::*;

    localparam int IN_W   = 11;
    localparam int DIGITS = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [IN_W-1:0] res = '0;
    logic            res_valid = 1'b0;
    logic [3:0]      dig;
    logic            dig_valid;
    logic            dig_ready = 1'b0;
    logic            dig_last;
    logic            busy;
    logic            drop_err;
    state_t          state_dbg;

    int checks   = 0;
    int failures = 0;
    int hs_count = 0;
    int ready_mode = 0;
    logic [4:0] exp_q[$];

    result_bcd_serializer #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .res       (res),
        .res_valid (res_valid),
        .dig       (dig),
        .dig_valid (dig_valid),
        .dig_ready (dig_ready),
        .dig_last  (dig_last),
        .busy      (busy),
        .drop_err  (drop_err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic int digit_at(input int v, input int i);
        int p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        return (v / p) % 10;
    endfunction

    function automatic int count_digits(input int v);
        int n = DIGITS;
`ifdef LEADING_ZERO_SUPPRESS_EN
        n = 1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (digit_at(v, i) != 0 && n == 1) n = i + 1;
        end
`endif
        return n;
    endfunction

    task automatic push_expected(input int v);
        int n;
        logic [3:0] d;
        logic l;
        n = count_digits(v);
        for (int i = n - 1; i >= 0; i--) begin
            d = 4'(digit_at(v, i));
            l = (i == 0);
            exp_q.push_back({l, d});
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: dig_ready = 1'b1;
            1: dig_ready = ~dig_ready;
            default: dig_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- scoreboard / compare ----------------
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [3:0] prev_dig   = '0;
    logic       prev_last  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready)
                check("stall_hold", {dig_valid, dig_last, dig}, {1'b1, prev_last, prev_dig});
            if (dig_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_digit actual=%0d required=none", dig);
                end else begin
                    check("dig_stream", {dig_last, dig}, exp_q[0]);
                    if (dig_ready) begin
                        void'(exp_q.pop_front());
                        hs_count++;
                    end
                end
            end
            prev_valid = dig_valid;
            prev_ready = dig_ready;
            prev_dig   = dig;
            prev_last  = dig_last;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int v);
        @(posedge clk);
        #1;
        res       = IN_W'(v);
        res_valid = 1'b1;
        push_expected(v);
        @(posedge clk);
        #1;
        res_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_busy_low"}, busy, 0);
        exp_q.delete();
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!dig_valid && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int v;
        int n;

        // model pins
        check("model_1395_d3", digit_at(1395, 3), 1);
        check("model_1395_d1", digit_at(1395, 1), 9);
        check("model_2047_d0", digit_at(2047, 0), 7);
`ifdef LEADING_ZERO_SUPPRESS_EN
        check("model_cnt_0", count_digits(0), 1);
        check("model_cnt_31", count_digits(31), 2);
`else
        check("model_cnt_0", count_digits(0), 4);
        check("model_cnt_31", count_digits(31), 4);
`endif

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dig_valid", dig_valid, 0);
        check("rst_dig", dig, 0);
        check("rst_dig_last", dig_last, 0);
        check("rst_busy", busy, 0);
        check("rst_drop_err", drop_err, 0);
        check("rst_state", state_dbg, IDLE);
        rst = 1'b0;

        // 1395 with ready high: latency and digits
        ready_mode = 0;
        send(1395);
        check("busy_in_conv", busy, 1);
        wait_valid(cyc);
        check("first_valid_cycle", cyc, 12);
        wait_done("t1395");

        // 2047 with toggling ready
        ready_mode = 1;
        hs_count = 0;
        send(2047);
        wait_done("t2047");
        check("t2047_handshakes", hs_count, 4);

        // 31 with a colliding pulse in cycle 5
        ready_mode = 0;
        send(31);
        repeat (3) @(posedge clk);
        #1;
        res       = IN_W'(999);
        res_valid = 1'b1;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        wait_done("t31");
        check("drop_err_set", drop_err, 1);

        // zero and small values
        send(0);
        wait_done("t0");
        send(7);
        wait_done("t7");
        check("drop_err_sticky", drop_err, 1);

        // reset during the second digit of 1234
        send(1234);
        wait_valid(cyc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_dig_valid", dig_valid, 0);
        check("midrst_dig", dig, 0);
        check("midrst_dig_last", dig_last, 0);
        check("midrst_busy", busy, 0);
        check("midrst_drop_err", drop_err, 0);
        exp_q.delete();
        rst = 1'b0;
        send(56);
        wait_done("t56");

        // back-to-back: next pulse right after the last handshake
        send(808);
        n = 0;
        while (!(dig_valid && dig_last) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_last_seen", n < 60, 1);
        @(posedge clk);
        #1;
        res       = IN_W'(1999);
        res_valid = 1'b1;
        push_expected(1999);
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        wait_done("b2b");
        check("b2b_no_drop", drop_err, 0);

        // randomized values and ready pattern
        ready_mode = 2;
        for (int k = 0; k < 30; k++) begin
            v = $urandom_range(0, 2047);
            send(v);
            wait_done("rand");
        end
        check("final_no_drop", drop_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
